pc_gen_unit: RTL and testbench



---
 rtl/cpu_defs_pkg.sv | 14 +
 rtl/pc_redirect_arb.sv | 51 +++++
 rtl/pc_gen_unit.sv | 119 +++++++++++
 tb/tb_pc_gen_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU front-end definitions: redirect priority encoding and default vectors.
package cpu_defs_pkg;

  typedef logic [1:0] prio_t;

  localparam prio_t PRIO_NONE = 2'd0;
  localparam prio_t PRIO_BR   = 2'd1;
  localparam prio_t PRIO_ERET = 2'd2;
  localparam prio_t PRIO_EXC  = 2'd3;

  localparam logic [31:0] DEF_RESET_VEC = 32'hbfc0_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'hbfc0_0380;

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational redirect arbiter: picks the incoming request by fixed priority,
// then chooses between it and the buffered (pending) redirect.
module pc_redirect_arb
  import cpu_defs_pkg::*;
#(
  parameter int                 WIDTH   = 32,
  parameter logic [WIDTH-1:0]   EXC_VEC = WIDTH'(DEF_EXC_VEC)
) (
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [WIDTH-1:0] epc,
  input  logic             br_req,
  input  logic [WIDTH-1:0] br_target,
  input  logic             pend_valid,
  input  logic [1:0]       pend_prio,
  input  logic [WIDTH-1:0] pend_target,
  output logic [1:0]       in_prio,
  output logic [WIDTH-1:0] in_target,
  output logic             sel_valid,
  output logic [1:0]       sel_prio,
  output logic [WIDTH-1:0] sel_target
);

  always_comb begin
    in_prio   = PRIO_NONE;
    in_target = '0;
    if (exc_req) begin
      in_prio   = PRIO_EXC;
      in_target = EXC_VEC;
    end else if (eret_req) begin
      in_prio   = PRIO_ERET;
      in_target = epc;
    end else if (br_req) begin
      in_prio   = PRIO_BR;
      in_target = br_target;
    end
  end

  // Pending only wins when strictly higher; on a tie the fresh request is taken.
  always_comb begin
    sel_valid = pend_valid | (in_prio != PRIO_NONE);
    if (pend_valid && (pend_prio > in_prio)) begin
      sel_prio   = pend_prio;
      sel_target = pend_target;
    end else begin
      sel_prio   = in_prio;
      sel_target = in_target;
    end
  end

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch-stage program counter: priority redirects, stall with redirect buffering,
// and a valid/ready instruction-memory request.
module pc_gen_unit
  import cpu_defs_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(DEF_EXC_VEC),
  parameter int unsigned      INC       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [WIDTH-1:0] epc,
  input  logic             br_req,
  input  logic [WIDTH-1:0] br_target,
  input  logic             if_ready,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_addr,
  output logic             pc_misalign,
  output logic             redirect_done
);

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             if_valid_q;
  logic             pend_valid_q, pend_valid_d;
  logic [1:0]       pend_prio_q, pend_prio_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;
  logic             redirect_done_q, redirect_done_d;

  logic [1:0]       in_prio;
  logic [WIDTH-1:0] in_target;
  logic             sel_valid;
  logic [1:0]       sel_prio;
  logic [WIDTH-1:0] sel_target;
  logic             acc;

  function automatic logic [WIDTH-1:0] pc_inc(input logic [WIDTH-1:0] pc);
    return pc + INC_W;
  endfunction

  pc_redirect_arb #(
    .WIDTH   (WIDTH),
    .EXC_VEC (EXC_VEC)
  ) u_arb (
    .exc_req     (exc_req),
    .eret_req    (eret_req),
    .epc         (epc),
    .br_req      (br_req),
    .br_target   (br_target),
    .pend_valid  (pend_valid_q),
    .pend_prio   (pend_prio_q),
    .pend_target (pend_target_q),
    .in_prio     (in_prio),
    .in_target   (in_target),
    .sel_valid   (sel_valid),
    .sel_prio    (sel_prio),
    .sel_target  (sel_target)
  );

  assign acc = if_valid_q & if_ready & ~stall;

  always_comb begin
    pc_d            = pc_q;
    pend_valid_d    = pend_valid_q;
    pend_prio_d     = pend_prio_q;
    pend_target_d   = pend_target_q;
    redirect_done_d = 1'b0;
    if (stall) begin
      // A lower-priority request never displaces a buffered higher one.
      if ((in_prio != PRIO_NONE) && (in_prio >= pend_prio_q)) begin
        pend_valid_d  = 1'b1;
        pend_prio_d   = in_prio;
        pend_target_d = in_target;
      end
    end else if (sel_valid) begin
      // Redirect ignores if_ready: the outstanding unaccepted fetch is dropped.
      pc_d            = sel_target;
      pend_valid_d    = 1'b0;
      pend_prio_d     = PRIO_NONE;
      redirect_done_d = 1'b1;
    end else if (acc) begin
      pc_d = pc_inc(pc_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q            <= RESET_VEC;
      if_valid_q      <= 1'b0;
      pend_valid_q    <= 1'b0;
      pend_prio_q     <= PRIO_NONE;
      redirect_done_q <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      if_valid_q      <= 1'b1;
      pend_valid_q    <= pend_valid_d;
      pend_prio_q     <= pend_prio_d;
      redirect_done_q <= redirect_done_d;
    end
  end

  always_ff @(posedge clk) begin
    pend_target_q <= pend_target_d;
  end

  assign if_valid      = if_valid_q;
  assign if_addr       = pc_q;
  assign pc_misalign   = |pc_q[1:0];
  assign redirect_done = redirect_done_q;

  logic unused_sel_prio;
  assign unused_sel_prio = ^sel_prio;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Scoreboard bench for pc_gen_unit: driver pushes model expectations, monitor pops and compares.
module tb_pc_gen_unit;

  localparam logic [31:0] RV  = 32'hbfc0_0000;
  localparam logic [31:0] EV  = 32'hbfc0_0380;
  localparam logic [31:0] INC = 32'd4;

  logic        clk = 1'b0;
  logic        rst, stall, exc_req, eret_req, br_req, if_ready;
  logic [31:0] epc, br_target;
  logic        if_valid, pc_misalign, redirect_done;
  logic [31:0] if_addr;

  pc_gen_unit dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .exc_req       (exc_req),
    .eret_req      (eret_req),
    .epc           (epc),
    .br_req        (br_req),
    .br_target     (br_target),
    .if_ready      (if_ready),
    .if_valid      (if_valid),
    .if_addr       (if_addr),
    .pc_misalign   (pc_misalign),
    .redirect_done (redirect_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [31:0] a;
    logic        mis;
    logic        rd;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state: what the fetch stage should look like after each edge.
  logic [31:0] m_pc;
  logic        m_v;
  logic        m_rd;
  logic        m_pend;
  int          m_pend_prio;
  logic [31:0] m_pend_tgt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_cycle(input logic r, input logic st, input logic ex, input logic er,
                             input logic [31:0] ep, input logic b, input logic [31:0] bt,
                             input logic rdy);
    int          ip;
    logic [31:0] it;
    exp_t        e;
    if (r) begin
      m_pc = RV; m_v = 0; m_rd = 0; m_pend = 0; m_pend_prio = 0;
    end else begin
      ip = 0; it = 32'h0;
      if (ex)      begin ip = 3; it = EV; end
      else if (er) begin ip = 2; it = ep; end
      else if (b)  begin ip = 1; it = bt; end
      if (st) begin
        if (ip != 0 && ip >= m_pend_prio) begin
          m_pend = 1; m_pend_prio = ip; m_pend_tgt = it;
        end
        m_rd = 0;
      end else if (ip != 0 || m_pend) begin
        m_pc = (m_pend && m_pend_prio > ip) ? m_pend_tgt : it;
        m_pend = 0; m_pend_prio = 0; m_rd = 1;
      end else begin
        if (m_v && rdy) m_pc = m_pc + INC;
        m_rd = 0;
      end
      m_v = 1;
    end
    e.v = m_v; e.a = m_pc; e.mis = (m_pc[1:0] != 2'b00); e.rd = m_rd;
    exp_q.push_back(e);
  endtask

  task automatic apply(input logic r, input logic st, input logic ex, input logic er,
                       input logic [31:0] ep, input logic b, input logic [31:0] bt,
                       input logic rdy);
    rst = r; stall = st; exc_req = ex; eret_req = er; epc = ep;
    br_req = b; br_target = bt; if_ready = rdy;
    model_cycle(r, st, ex, er, ep, b, bt, rdy);
  endtask

  task automatic step(input logic r, input logic st, input logic ex, input logic er,
                      input logic [31:0] ep, input logic b, input logic [31:0] bt,
                      input logic rdy);
    @(negedge clk);
    apply(r, st, ex, er, ep, b, bt, rdy);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every edge the DUT presents a new state, compare it with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_if_valid", {31'd0, if_valid}, {31'd0, e.v});
        chk("sb_if_addr", if_addr, e.a);
        chk("sb_misalign", {31'd0, pc_misalign}, {31'd0, e.mis});
        chk("sb_redirect_done", {31'd0, redirect_done}, {31'd0, e.rd});
      end
    end
  end

  initial begin
    logic        r, st, ex, er, b, rdy;
    logic [31:0] ep, bt;
    apply(1, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    step(1, 0, 0, 0, 32'h0, 0, 32'h0, 1);
    after_edge();
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_addr", if_addr, RV);

    // Sequential fetch from reset vector, then back-pressure.
    step(0, 0, 0, 0, 32'h0, 0, 32'h0, 1);
    step(0, 0, 0, 0, 32'h0, 0, 32'h0, 1);
    step(0, 0, 0, 0, 32'h0, 0, 32'h0, 1);
    after_edge();
    chk("seq_addr2", if_addr, 32'hbfc0_0008);
    step(0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    step(0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    after_edge();
    chk("hold_addr", if_addr, 32'hbfc0_0008);
    step(0, 0, 0, 0, 32'h0, 0, 32'h0, 1);
    after_edge();
    chk("adv_addr", if_addr, 32'hbfc0_000c);

    // Stalled br then exc: exc wins.
    step(0, 1, 0, 0, 32'h0, 1, 32'h8000_1000, 1);
    step(0, 1, 1, 0, 32'h0, 0, 32'h0, 1);
    step(0, 0, 0, 0, 32'h0, 0, 32'h0, 1);
    after_edge();
    chk("br_exc_addr", if_addr, EV);
    chk("br_exc_rd", {31'd0, redirect_done}, 32'd1);
    step(0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    after_edge();
    chk("rd_single_pulse", {31'd0, redirect_done}, 32'd0);

    // Stalled exc then br: br must not overwrite.
    step(0, 1, 1, 0, 32'h0, 0, 32'h0, 1);
    step(0, 1, 0, 0, 32'h0, 1, 32'h8000_1000, 1);
    step(0, 0, 0, 0, 32'h0, 0, 32'h0, 1);
    after_edge();
    chk("exc_br_addr", if_addr, EV);

    // Pending eret, then exc+br together on release.
    step(0, 1, 0, 1, 32'h8000_0200, 0, 32'h0, 1);
    step(0, 0, 1, 0, 32'h0, 1, 32'h8000_1000, 1);
    after_edge();
    chk("exc_over_pend_addr", if_addr, EV);
    step(0, 0, 0, 0, 32'h0, 0, 32'h0, 1);
    after_edge();
    chk("seq_after_exc", if_addr, 32'hbfc0_0384);

    // Wrap-around and misalignment.
    step(0, 0, 0, 0, 32'h0, 1, 32'hffff_fffc, 0);
    step(0, 0, 0, 0, 32'h0, 0, 32'h0, 1);
    after_edge();
    chk("wrap_addr", if_addr, 32'h0000_0000);
    step(0, 0, 0, 0, 32'h0, 1, 32'h8000_0002, 1);
    after_edge();
    chk("misalign_flag", {31'd0, pc_misalign}, 32'd1);
    chk("misalign_addr", if_addr, 32'h8000_0002);

    // Reset during stall discards pending branch.
    step(0, 1, 0, 0, 32'h0, 1, 32'h8000_1000, 1);
    step(1, 1, 0, 0, 32'h0, 0, 32'h0, 1);
    step(0, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    after_edge();
    chk("rst_pend_addr", if_addr, RV);
    chk("rst_pend_rd", {31'd0, redirect_done}, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 99) < 2);
      st  = ($urandom_range(0, 99) < 30);
      ex  = ($urandom_range(0, 99) < 5);
      er  = ($urandom_range(0, 99) < 10);
      b   = ($urandom_range(0, 99) < 15);
      rdy = ($urandom_range(0, 99) < 70);
      ep  = $urandom();
      bt  = $urandom();
      if ($urandom_range(0, 3) != 0) begin
        ep[1:0] = 2'b00;
        bt[1:0] = 2'b00;
      end
      step(r, st, ex, er, ep, b, bt, rdy);
    end
    step(0, 0, 0, 0, 32'h0, 0, 32'h0, 1);
    after_edge();
    after_edge();
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
